// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one unified memory between instruction fetch (IF) and load/store (MA).
// MA has priority; a saturating starvation counter guarantees IF a grant after STARVE_LIMIT MA grants.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IF_READ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    output logic [DATA_W-1:0] IF_RDATA,
    output logic              IF_BUSYWAIT,
    input  logic              MA_READ,
    input  logic              MA_WRITE,
    input  logic [ADDR_W-1:0] MA_ADDR,
    input  logic [DATA_W-1:0] MA_WDATA,
    input  logic [3:0]        MA_BYTEEN,
    output logic [DATA_W-1:0] MA_RDATA,
    output logic              MA_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic [3:0]        MEM_BYTEEN,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_ACK
);

    localparam int unsigned CNT_W = ($clog2(STARVE_LIMIT + 1) > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_MA = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_starve;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [3:0]        r_mem_byteen;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ma_rdata;

    logic w_ma_req;
    logic w_starved;
    logic w_if_wins;
    logic w_if_ack;
    logic w_ma_ack;

    assign w_ma_req  = MA_READ | MA_WRITE;
    assign w_starved = (r_starve == CNT_W'(STARVE_LIMIT));
    assign w_if_wins = IF_READ & (~w_ma_req | w_starved);
    assign w_if_ack  = (r_state == SERVE_IF) & MEM_ACK;
    assign w_ma_ack  = (r_state == SERVE_MA) & MEM_ACK;

    // Stall and read-data paths bypass the holding registers during the ack cycle.
    assign IF_BUSYWAIT = IF_READ  & ~w_if_ack;
    assign MA_BUSYWAIT = w_ma_req & ~w_ma_ack;
    assign IF_RDATA    = w_if_ack ? MEM_RDATA : r_if_rdata;
    assign MA_RDATA    = w_ma_ack ? MEM_RDATA : r_ma_rdata;

    assign MEM_READ   = r_mem_read;
    assign MEM_WRITE  = r_mem_write;
    assign MEM_ADDR   = r_mem_addr;
    assign MEM_WDATA  = r_mem_wdata;
    assign MEM_BYTEEN = r_mem_byteen;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_starve     <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_byteen <= 4'b0000;
            r_if_rdata   <= '0;
            r_ma_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_if_wins) begin
                        r_state      <= SERVE_IF;
                        r_starve     <= '0;
                        r_mem_read   <= 1'b1;
                        r_mem_write  <= 1'b0;
                        r_mem_addr   <= IF_ADDR;
                        r_mem_wdata  <= '0;
                        r_mem_byteen <= 4'b1111;
                    end else if (w_ma_req) begin
                        r_state      <= SERVE_MA;
                        // A simultaneous read+write is treated as a store.
                        r_mem_read   <= ~MA_WRITE;
                        r_mem_write  <= MA_WRITE;
                        r_mem_addr   <= MA_ADDR;
                        r_mem_wdata  <= MA_WDATA;
                        r_mem_byteen <= MA_BYTEEN;
                        if (!IF_READ) begin
                            r_starve <= '0;
                        end else if (!w_starved) begin
                            r_starve <= r_starve + CNT_W'(1);
                        end
                    end else begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (!IF_READ) begin
                            r_starve <= '0;
                        end
                    end
                end
                SERVE_IF, SERVE_MA: begin
                    if (MEM_ACK) begin
                        r_state     <= IDLE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (r_state == SERVE_IF) begin
                            r_if_rdata <= MEM_RDATA;
                        end else begin
                            r_ma_rdata <= MEM_RDATA;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single-transaction vectors plus hand-written
// sequences for back-to-back arbitration, starvation, input freezing, reset and stray acks.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IF_READ;
    logic [31:0] IF_ADDR;
    logic [31:0] IF_RDATA;
    logic        IF_BUSYWAIT;
    logic        MA_READ;
    logic        MA_WRITE;
    logic [31:0] MA_ADDR;
    logic [31:0] MA_WDATA;
    logic [3:0]  MA_BYTEEN;
    logic [31:0] MA_RDATA;
    logic        MA_BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_BYTEEN;
    logic [31:0] MEM_RDATA;
    logic        MEM_ACK;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .IF_READ(IF_READ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_BUSYWAIT(IF_BUSYWAIT),
        .MA_READ(MA_READ), .MA_WRITE(MA_WRITE), .MA_ADDR(MA_ADDR), .MA_WDATA(MA_WDATA),
        .MA_BYTEEN(MA_BYTEEN), .MA_RDATA(MA_RDATA), .MA_BUSYWAIT(MA_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_BYTEEN(MEM_BYTEEN), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        if_rd;
        logic [31:0] if_addr;
        logic        ma_rd;
        logic        ma_wr;
        logic [31:0] ma_addr;
        logic [31:0] ma_wdata;
        logic [3:0]  ma_be;
        int          dly;
        logic [31:0] rdata;
        logic        win_if;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drop_reqs();
        IF_READ  = 1'b0;
        MA_READ  = 1'b0;
        MA_WRITE = 1'b0;
    endtask

    // One transaction from IDLE: grant, optional wait states, ack, release.
    task automatic run_vec(input int idx, input vec_t v);
        @(negedge CLK);
        IF_READ = v.if_rd;   IF_ADDR  = v.if_addr;
        MA_READ = v.ma_rd;   MA_WRITE = v.ma_wr;   MA_ADDR = v.ma_addr;
        MA_WDATA = v.ma_wdata; MA_BYTEEN = v.ma_be;
        #1;
        chk($sformatf("v%0d_idle_if_bw", idx), 32'(IF_BUSYWAIT), 32'(v.if_rd));
        chk($sformatf("v%0d_idle_ma_bw", idx), 32'(MA_BUSYWAIT), 32'(v.ma_rd | v.ma_wr));
        @(negedge CLK);
        chk($sformatf("v%0d_mem_read", idx),  32'(MEM_READ),   32'(v.e_rd));
        chk($sformatf("v%0d_mem_write", idx), 32'(MEM_WRITE),  32'(v.e_wr));
        chk($sformatf("v%0d_mem_addr", idx),  MEM_ADDR,        v.e_addr);
        chk($sformatf("v%0d_mem_wdata", idx), MEM_WDATA,       v.e_wdata);
        chk($sformatf("v%0d_mem_be", idx),    32'(MEM_BYTEEN), 32'(v.e_be));
        for (int c = 0; c < v.dly; c++) begin
            @(negedge CLK);
            chk($sformatf("v%0d_wait%0d_read", idx, c),  32'(MEM_READ),  32'(v.e_rd));
            chk($sformatf("v%0d_wait%0d_write", idx, c), 32'(MEM_WRITE), 32'(v.e_wr));
        end
        MEM_ACK = 1'b1;
        MEM_RDATA = v.rdata;
        #1;
        if (v.win_if) begin
            chk($sformatf("v%0d_ack_if_bw", idx), 32'(IF_BUSYWAIT), 32'd0);
            chk($sformatf("v%0d_ack_if_rdata", idx), IF_RDATA, v.rdata);
            chk($sformatf("v%0d_ack_ma_bw", idx), 32'(MA_BUSYWAIT), 32'(v.ma_rd | v.ma_wr));
        end else begin
            chk($sformatf("v%0d_ack_ma_bw", idx), 32'(MA_BUSYWAIT), 32'd0);
            chk($sformatf("v%0d_ack_ma_rdata", idx), MA_RDATA, v.rdata);
            chk($sformatf("v%0d_ack_if_bw", idx), 32'(IF_BUSYWAIT), 32'(v.if_rd));
        end
        @(negedge CLK);
        MEM_ACK = 1'b0;
        MEM_RDATA = 32'h0;
        drop_reqs();
        #1;
        chk($sformatf("v%0d_post_read", idx),  32'(MEM_READ),  32'd0);
        chk($sformatf("v%0d_post_write", idx), 32'(MEM_WRITE), 32'd0);
        chk($sformatf("v%0d_post_hold", idx), v.win_if ? IF_RDATA : MA_RDATA, v.rdata);
    endtask

    initial begin
        vt[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 32'h00500093,
                  1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF};
        vt[1] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011, 0, 32'h11112222,
                  1'b0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011};
        vt[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h204, 32'h0, 4'hF, 2, 32'hCAFEF00D,
                  1'b0, 1'b1, 1'b0, 32'h204, 32'h0, 4'hF};
        vt[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h12345678, 4'hF, 0, 32'h0,
                  1'b0, 1'b0, 1'b1, 32'h200, 32'h12345678, 4'hF};
        vt[4] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 1, 32'h0BADCAFE,
                  1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF};
        vt[5] = '{1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h999, 32'hAAAA5555, 4'h5, 0, 32'h13579BDF,
                  1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 4'hF};

        RESET = 1'b1; MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
        IF_ADDR = 32'h0; MA_ADDR = 32'h0; MA_WDATA = 32'h0; MA_BYTEEN = 4'h0;
        drop_reqs();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rst_mem_read", 32'(MEM_READ), 32'd0);
        chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
        chk("rst_mem_addr", MEM_ADDR, 32'h0);
        chk("rst_mem_be", 32'(MEM_BYTEEN), 32'd0);
        chk("rst_if_rdata", IF_RDATA, 32'h0);
        chk("rst_ma_rdata", MA_RDATA, 32'h0);
        chk("rst_if_bw", 32'(IF_BUSYWAIT), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

        // MA write beats IF, one idle cycle, then IF served.
        @(negedge CLK);
        IF_READ = 1'b1; IF_ADDR = 32'h20;
        MA_WRITE = 1'b1; MA_ADDR = 32'h100; MA_WDATA = 32'hDEADBEEF; MA_BYTEEN = 4'b0011;
        @(negedge CLK);
        chk("b2b_ma_write", 32'(MEM_WRITE), 32'd1);
        chk("b2b_ma_addr", MEM_ADDR, 32'h100);
        chk("b2b_ma_be", 32'(MEM_BYTEEN), 32'b0011);
        MEM_ACK = 1'b1; MEM_RDATA = 32'h0;
        #1;
        chk("b2b_ma_bw_ack", 32'(MA_BUSYWAIT), 32'd0);
        chk("b2b_if_bw_held", 32'(IF_BUSYWAIT), 32'd1);
        @(negedge CLK);
        MEM_ACK = 1'b0; MA_WRITE = 1'b0;
        #1;
        chk("b2b_idle_read", 32'(MEM_READ), 32'd0);
        chk("b2b_idle_write", 32'(MEM_WRITE), 32'd0);
        chk("b2b_idle_if_bw", 32'(IF_BUSYWAIT), 32'd1);
        @(negedge CLK);
        chk("b2b_if_read", 32'(MEM_READ), 32'd1);
        chk("b2b_if_addr", MEM_ADDR, 32'h20);
        chk("b2b_if_wdata", MEM_WDATA, 32'h0);
        chk("b2b_if_be", 32'(MEM_BYTEEN), 32'hF);
        MEM_ACK = 1'b1; MEM_RDATA = 32'h00A00113;
        #1;
        chk("b2b_if_bw_ack", 32'(IF_BUSYWAIT), 32'd0);
        chk("b2b_if_rdata", IF_RDATA, 32'h00A00113);
        @(negedge CLK);
        MEM_ACK = 1'b0; drop_reqs();
        @(negedge CLK);

        // Starvation: four MA grants, then IF, then MA again once the counter has cleared.
        IF_READ = 1'b1; IF_ADDR = 32'h600;
        MA_READ = 1'b1; MA_ADDR = 32'h500;
        for (int g = 0; g < 6; g++) begin
            @(negedge CLK);
            chk($sformatf("starve_g%0d_read", g), 32'(MEM_READ), 32'd1);
            chk($sformatf("starve_g%0d_addr", g), MEM_ADDR, (g == 4) ? 32'h600 : 32'h500);
            MEM_ACK = 1'b1; MEM_RDATA = 32'(g);
            @(negedge CLK);
            MEM_ACK = 1'b0;
            chk($sformatf("starve_g%0d_gap", g), 32'(MEM_READ), 32'd0);
        end
        drop_reqs();
        @(negedge CLK);

        // Requester changes while being served must not reach the memory port.
        MA_WRITE = 1'b1; MA_ADDR = 32'h700; MA_WDATA = 32'h01020304; MA_BYTEEN = 4'h8;
        @(negedge CLK);
        MA_WRITE = 1'b0; MA_READ = 1'b1; MA_ADDR = 32'h7FC; MA_WDATA = 32'h0; MA_BYTEEN = 4'hF;
        @(negedge CLK);
        chk("frz_write", 32'(MEM_WRITE), 32'd1);
        chk("frz_read", 32'(MEM_READ), 32'd0);
        chk("frz_addr", MEM_ADDR, 32'h700);
        chk("frz_wdata", MEM_WDATA, 32'h01020304);
        chk("frz_be", 32'(MEM_BYTEEN), 32'h8);
        MEM_ACK = 1'b1; MEM_RDATA = 32'h0;
        @(negedge CLK);
        MEM_ACK = 1'b0; drop_reqs();
        @(negedge CLK);

        // Reset in the middle of an MA read; a late ack must not release MA.
        MA_READ = 1'b1; MA_ADDR = 32'h800;
        @(negedge CLK);
        chk("rstmid_granted", 32'(MEM_READ), 32'd1);
        RESET = 1'b1;
        #1;
        chk("rstmid_ma_bw", 32'(MA_BUSYWAIT), 32'd1);
        @(negedge CLK);
        RESET = 1'b0; MEM_ACK = 1'b1; MEM_RDATA = 32'h99;
        #1;
        chk("rstmid_read", 32'(MEM_READ), 32'd0);
        chk("rstmid_addr", MEM_ADDR, 32'h0);
        chk("rstmid_ma_rdata", MA_RDATA, 32'h0);
        chk("rstmid_if_rdata", IF_RDATA, 32'h0);
        chk("rstmid_late_ack_bw", 32'(MA_BUSYWAIT), 32'd1);
        @(negedge CLK);
        MEM_ACK = 1'b0;
        #1;
        chk("rstmid_regrant", 32'(MEM_READ), 32'd1);
        chk("rstmid_ack_ignored", MA_RDATA, 32'h0);
        MEM_ACK = 1'b1; MEM_RDATA = 32'h00005A5A;
        @(negedge CLK);
        MEM_ACK = 1'b0; drop_reqs();
        chk("rstmid_done_rdata", MA_RDATA, 32'h00005A5A);
        @(negedge CLK);

        // Stray ack in IDLE with no request.
        MEM_ACK = 1'b1; MEM_RDATA = 32'h777;
        #1;
        chk("stray_if_bw", 32'(IF_BUSYWAIT), 32'd0);
        chk("stray_ma_bw", 32'(MA_BUSYWAIT), 32'd0);
        chk("stray_ma_rdata", MA_RDATA, 32'h00005A5A);
        @(negedge CLK);
        MEM_ACK = 1'b0;
        #1;
        chk("stray_read", 32'(MEM_READ), 32'd0);
        chk("stray_write", 32'(MEM_WRITE), 32'd0);
        chk("stray_hold_ma", MA_RDATA, 32'h00005A5A);
        chk("stray_hold_if", IF_RDATA, 32'h0);
        @(negedge CLK);
        chk("stray_still_idle", 32'(MEM_READ | MEM_WRITE), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
